// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

  // Loader FSM states
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_DATA   = 3'd3,
    S_WRITE  = 3'd4,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } state_e;

  // Frame layout: 2-byte big-endian word count, then 4 bytes per word
  localparam int LEN_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_word_assembler.sv
// Packs a byte stream MSB-first into 32-bit words. The byte counter wraps
// every BYTES_PER_WORD bytes; word_ready marks a complete word until cleared.
module imem_word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        clear_i,
  input  logic        byte_en_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        last_o,
  output logic        word_ready_o
);

  logic [31:0] word_q, word_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        rdy_q, rdy_d;

  // Next state: clear drops count/flag only; stale word bits are shifted out
  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    rdy_d  = rdy_q;
    if (clear_i) begin
      cnt_d = '0;
      rdy_d = 1'b0;
    end else if (byte_en_i) begin
      word_d = {word_q[23:0], byte_i};
      cnt_d  = cnt_q + 2'd1;
      rdy_d  = (cnt_q == 2'(BYTES_PER_WORD - 1));
    end
  end

  // Shift register, byte counter and ready flag
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      word_q <= '0;
      cnt_q  <= '0;
      rdy_q  <= 1'b0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
      rdy_q  <= rdy_d;
    end
  end

  assign word_o       = word_q;
  assign last_o       = (cnt_q == 2'(BYTES_PER_WORD - 1));
  assign word_ready_o = rdy_q;

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction memory programmer: receives a length-prefixed
// byte image, writes big-endian words sequentially, and holds the CPU in
// reset until the full image has been written.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        start_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic        imem_we_o,
  output logic [31:0] imem_addr_o,
  output logic [31:0] imem_wdata_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic        cpu_reset_n_o
);

  // Largest legal image, in words; compared in 17 bits so 2**16 fits
  localparam logic [16:0] MAX_WORDS = 17'(2 ** DEPTH);

  state_e           state_q, state_d;
  logic [15:0]      n_q, n_d;
  logic [DEPTH-1:0] k_q, k_d;

  logic        xfer;
  logic        asm_clr;
  logic        asm_en;
  logic        asm_last;
  logic        asm_rdy;
  logic [31:0] asm_word;
  logic [15:0] len_full;
  logic        k_last;

  imem_word_assembler u_asm (
    .clk_i        (clk_i),
    .reset_n_i    (reset_n_i),
    .clear_i      (asm_clr),
    .byte_en_i    (asm_en),
    .byte_i       (rx_data_i),
    .word_o       (asm_word),
    .last_o       (asm_last),
    .word_ready_o (asm_rdy)
  );

  // Moore decode: every output is a function of registered state only
  assign rx_ready_o    = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) || (state_q == S_DATA);
  assign busy_o        = rx_ready_o || (state_q == S_WRITE);
  assign done_o        = (state_q == S_DONE);
  assign error_o       = (state_q == S_ERR);
  assign cpu_reset_n_o = (state_q == S_DONE);
  // word_ready is always set in WRITE; gating on it keeps partial words out
  assign imem_we_o     = (state_q == S_WRITE) && asm_rdy;
  assign imem_addr_o   = 32'({k_q, 2'b00});
  assign imem_wdata_o  = asm_word;

  assign xfer     = rx_valid_i && rx_ready_o;
  assign asm_en   = xfer && (state_q == S_DATA);
  assign len_full = {n_q[15:8], rx_data_i};
  assign k_last   = (17'(k_q) == ({1'b0, n_q} - 17'd1));

  // Next-state logic for the FSM, word count N and word index k
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    k_d     = k_q;
    asm_clr = 1'b0;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start_i) begin
          state_d = S_LEN_HI;
          k_d     = '0;
          asm_clr = 1'b1;
        end
      end
      S_LEN_HI: begin
        if (xfer) begin
          n_d[15:8] = rx_data_i;
          state_d   = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (xfer) begin
          n_d[7:0] = rx_data_i;
          if (len_full == 16'd0)                state_d = S_DONE;
          else if ({1'b0, len_full} > MAX_WORDS) state_d = S_ERR;
          else                                   state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (xfer && asm_last) state_d = S_WRITE;
      end
      S_WRITE: begin
        asm_clr = 1'b1;
        if (k_last) begin
          state_d = S_DONE;
        end else begin
          k_d     = k_q + 1'b1;
          state_d = S_DATA;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, length and index registers
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      k_q     <= k_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: framing, latency, length errors,
// stalls, mid-load reset and ignored start.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        busy;
  logic        done;
  logic        error;
  logic        cpu_reset_n;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int t0;

  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];

  imem_loader #(.DEPTH(8)) dut (
    .clk_i        (clk),
    .reset_n_i    (reset_n),
    .start_i      (start),
    .rx_data_i    (rx_data),
    .rx_valid_i   (rx_valid),
    .rx_ready_o   (rx_ready),
    .imem_we_o    (imem_we),
    .imem_addr_o  (imem_addr),
    .imem_wdata_o (imem_wdata),
    .busy_o       (busy),
    .done_o       (done),
    .error_o      (error),
    .cpu_reset_n_o(cpu_reset_n)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Log every write strobe, sampled mid-cycle
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wr_addr.push_back(imem_addr);
      wr_data.push_back(imem_wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Present a byte and hold it until it is accepted (bounded wait)
  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (rx_ready === 1'b1) begin
        tick();
        ok = 1;
        break;
      end
      tick();
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL send_byte timeout observed=rx_ready_low expected=accept byte %h", b);
    end
  endtask

  task automatic idle_cycles(input int n);
    rx_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    reset_n  = 1'b0;
    start    = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    tick();
    tick();
    // Reset values
    check("rst_rx_ready", 32'(rx_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cpu_reset_n", 32'(cpu_reset_n), 32'd0);
    check("rst_addr", imem_addr, 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);
    reset_n = 1'b1;
    tick();

    // --- N=2 continuous stream ---
    pulse_start();
    check("t1_busy", 32'(busy), 32'd1);
    send_byte(8'h00);
    t0 = cyc;
    send_byte(8'h02);
    send_byte(8'h20); send_byte(8'h08); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h20); send_byte(8'h10); send_byte(8'h00); send_byte(8'h00);
    rx_valid = 1'b0;
    check("t1_we_last", 32'(imem_we), 32'd1);
    check("t1_ready_in_write", 32'(rx_ready), 32'd0);
    check("t1_done_early", 32'(done), 32'd0);
    tick();
    check("t1_latency", 32'(cyc - t0), 32'd11);
    check("t1_done", 32'(done), 32'd1);
    check("t1_cpu_reset_n", 32'(cpu_reset_n), 32'd1);
    check("t1_busy_done", 32'(busy), 32'd0);
    check("t1_nwrites", 32'(wr_addr.size()), 32'd2);
    if (wr_addr.size() == 2) begin
      check("t1_addr0", wr_addr[0], 32'h0000_0000);
      check("t1_data0", wr_data[0], 32'h2008_0000);
      check("t1_addr1", wr_addr[1], 32'h0000_0004);
      check("t1_data1", wr_data[1], 32'h2010_0000);
    end
    wr_addr.delete(); wr_data.delete();

    // --- Empty image ---
    pulse_start();
    check("t2_done_cleared", 32'(done), 32'd0);
    check("t2_cpu_held", 32'(cpu_reset_n), 32'd0);
    send_byte(8'h00);
    send_byte(8'h00);
    rx_valid = 1'b0;
    check("t2_done", 32'(done), 32'd1);
    tick();
    check("t2_nwrites", 32'(wr_addr.size()), 32'd0);

    // --- Oversized image (N=257 > 256) ---
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h01);
    rx_valid = 1'b0;
    check("t3_error", 32'(error), 32'd1);
    check("t3_cpu_reset_n", 32'(cpu_reset_n), 32'd0);
    check("t3_rx_ready", 32'(rx_ready), 32'd0);
    check("t3_busy", 32'(busy), 32'd0);
    tick();
    check("t3_error_held", 32'(error), 32'd1);
    pulse_start();
    check("t3_error_cleared", 32'(error), 32'd0);
    check("t3_busy_restart", 32'(busy), 32'd1);

    // --- N=1 with stalls (already in LEN_HI) ---
    send_byte(8'h00); idle_cycles(1);
    send_byte(8'h01); idle_cycles(1);
    send_byte(8'h11); idle_cycles(1);
    send_byte(8'h09); idle_cycles(3);
    check("t4_stall_ready", 32'(rx_ready), 32'd1);
    check("t4_stall_nowrite", 32'(wr_addr.size()), 32'd0);
    send_byte(8'h00); idle_cycles(1);
    send_byte(8'h07);
    rx_valid = 1'b1;
    rx_data  = 8'hEE;
    check("t4_we", 32'(imem_we), 32'd1);
    check("t4_ready_in_write", 32'(rx_ready), 32'd0);
    tick();
    rx_valid = 1'b0;
    check("t4_done", 32'(done), 32'd1);
    check("t4_nwrites", 32'(wr_addr.size()), 32'd1);
    if (wr_addr.size() == 1) begin
      check("t4_addr", wr_addr[0], 32'h0000_0000);
      check("t4_data", wr_data[0], 32'h1109_0007);
    end
    wr_addr.delete(); wr_data.delete();

    // --- Reset in the middle of word 1 ---
    pulse_start();
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3); send_byte(8'hA4);
    send_byte(8'hB1); send_byte(8'hB2); send_byte(8'hB3);
    rx_valid = 1'b0;
    check("t5_addr_pre", imem_addr, 32'h0000_0004);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("t5_rx_ready", 32'(rx_ready), 32'd0);
    check("t5_we", 32'(imem_we), 32'd0);
    check("t5_addr", imem_addr, 32'd0);
    check("t5_wdata", imem_wdata, 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_done", 32'(done), 32'd0);
    check("t5_error", 32'(error), 32'd0);
    check("t5_cpu_reset_n", 32'(cpu_reset_n), 32'd0);
    wr_addr.delete(); wr_data.delete();
    pulse_start();
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    rx_valid = 1'b0;
    tick();
    check("t5_reload_done", 32'(done), 32'd1);
    check("t5_reload_n", 32'(wr_addr.size()), 32'd1);
    if (wr_addr.size() == 1) begin
      check("t5_reload_addr", wr_addr[0], 32'h0000_0000);
      check("t5_reload_data", wr_data[0], 32'h0102_0304);
    end
    wr_addr.delete(); wr_data.delete();

    // --- start during DATA is ignored ---
    pulse_start();
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h00); send_byte(8'h00);
    start = 1'b1;
    send_byte(8'h00);
    start = 1'b0;
    check("t6_busy", 32'(busy), 32'd1);
    send_byte(8'h13);
    send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
    rx_valid = 1'b0;
    tick();
    check("t6_done", 32'(done), 32'd1);
    check("t6_nwrites", 32'(wr_addr.size()), 32'd2);
    if (wr_addr.size() == 2) begin
      check("t6_addr0", wr_addr[0], 32'h0000_0000);
      check("t6_data0", wr_data[0], 32'h0000_0013);
      check("t6_addr1", wr_addr[1], 32'h0000_0004);
      check("t6_data1", wr_data[1], 32'hDEAD_BEEF);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
